mem_access_unit: RTL and testbench

- Load/store front-end driving the simulation RAM's port: en, write_en, 4-bit write_sel, word address, write data, combinational read data.
- Takes one CPU memory request at a time: byte/halfword/word, signed/unsigned loads.
- Converts it to a word-aligned RAM access with byte-lane strobes.
- Shifts and sign-extends load data; flags misaligned and out-of-range accesses without touching RAM.

---
 rtl/mem_access_unit_pkg.sv | 61 ++++++
 rtl/mem_load_align.sv | 26 ++
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 tb/tb_mem_access_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: op and state encodings,
// byte-strobe constants and small decode helpers.
package mem_access_unit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_SB  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_WHOLD,
    S_DONE
  } state_e;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_SB:   return STRB_BYTE << off;
      OP_SH:   return STRB_HALF << off;
      OP_SW:   return STRB_WORD;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicating the data across lanes lets the strobes pick the right copy.
  function automatic logic [DATA_W-1:0] store_lanes(input logic [2:0] op, input logic [DATA_W-1:0] wdata);
    case (op)
      OP_SB:   return {4{wdata[7:0]}};
      OP_SH:   return {2{wdata[15:0]}};
      OP_SW:   return wdata;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner: shifts a RAM word by the byte offset and
// sign/zero-extends it according to the load op.
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  op,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (op)
      OP_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  result = {24'h000000, shifted[7:0]};
      OP_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  result = {16'h0000, shifted[15:0]};
      OP_LW:   result = shifted;
      default: result = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store front-end: turns CPU byte/half/word requests
// into word-aligned RAM accesses with byte strobes; all outputs registered.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int RAM_ADDR_BITS = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  ram_en,
  output logic                  ram_write_en,
  output logic [3:0]            ram_write_sel,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  state_e                state_reg, state_next;
  logic [2:0]            op_reg, op_next;
  logic [1:0]            off_reg, off_next;
  logic                  ready_next, resp_valid_next, resp_err_next;
  logic [31:0]           resp_rdata_next, ram_wdata_next, load_result;
  logic                  ram_en_next, ram_write_en_next;
  logic [3:0]            ram_write_sel_next;
  logic [ADDR_WIDTH-1:0] ram_addr_next, word_addr;
  logic                  req_bad;

  assign word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign req_bad   = is_misaligned(req_op, req_addr[1:0]) ||
                     (|req_addr[ADDR_WIDTH-1:RAM_ADDR_BITS]);

  mem_load_align u_align (
    .rdata  (ram_rdata),
    .offset (off_reg),
    .op     (op_reg),
    .result (load_result)
  );

  always_comb begin
    state_next         = state_reg;
    op_next            = op_reg;
    off_next           = off_reg;
    ready_next         = 1'b0;
    resp_valid_next    = 1'b0;
    resp_rdata_next    = '0;
    resp_err_next      = 1'b0;
    ram_en_next        = 1'b0;
    ram_write_en_next  = 1'b0;
    ram_write_sel_next = '0;
    ram_addr_next      = '0;
    ram_wdata_next     = '0;
    case (state_reg)
      S_IDLE: begin
        ready_next = 1'b1;
        if (req_valid && req_ready) begin
          ready_next = 1'b0;
          op_next    = req_op;
          off_next   = req_addr[1:0];
          if (req_bad) begin
            // Errors skip the RAM entirely and respond on the next cycle.
            state_next      = S_DONE;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else begin
            ram_en_next   = 1'b1;
            ram_addr_next = word_addr;
            if (is_store(req_op)) begin
              state_next         = S_WRITE;
              ram_write_en_next  = 1'b1;
              ram_write_sel_next = store_strobe(req_op, req_addr[1:0]);
              ram_wdata_next     = store_lanes(req_op, req_wdata);
            end else begin
              state_next = S_READ;
            end
          end
        end
      end
      S_READ: begin
        state_next      = S_DONE;
        resp_valid_next = 1'b1;
        resp_rdata_next = load_result;
      end
      S_WRITE: begin
        // Keep address/strobes/data steady while the RAM samples its write.
        state_next         = S_WHOLD;
        ram_en_next        = 1'b1;
        ram_addr_next      = ram_addr;
        ram_write_sel_next = ram_write_sel;
        ram_wdata_next     = ram_wdata;
      end
      S_WHOLD: begin
        state_next      = S_DONE;
        resp_valid_next = 1'b1;
      end
      S_DONE: begin
        state_next = S_IDLE;
        ready_next = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
        ready_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      op_reg        <= '0;
      off_reg       <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      ram_en        <= 1'b0;
      ram_write_en  <= 1'b0;
      ram_write_sel <= '0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      off_reg       <= off_next;
      req_ready     <= ready_next;
      resp_valid    <= resp_valid_next;
      resp_rdata    <= resp_rdata_next;
      resp_err      <= resp_err_next;
      ram_en        <= ram_en_next;
      ram_write_en  <= ram_write_en_next;
      ram_write_sel <= ram_write_sel_next;
      ram_addr      <= ram_addr_next;
      ram_wdata     <= ram_wdata_next;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected responses
// and RAM writes, negedge monitors pop and compare them.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_en;
  logic        ram_write_en;
  logic [3:0]  ram_write_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  mem_access_unit #(.ADDR_WIDTH(32), .RAM_ADDR_BITS(9)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .ram_en        (ram_en),
    .ram_write_en  (ram_write_en),
    .ram_write_sel (ram_write_sel),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct { logic [31:0] rdata; logic err; int at; } resp_t;
  typedef struct { logic [31:0] addr; logic [3:0] sel; logic [31:0] wdata; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];

  int checks = 0;
  int passed = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Simple RAM stand-in: 128 words, byte-strobed write, combinational read.
  logic [31:0] mem [128];
  int wr_count = 0;
  int en_count = 0;
  assign ram_rdata = mem[ram_addr[8:2]];

  always @(posedge clk) begin
    if (ram_en) en_count <= en_count + 1;
    if (ram_en && ram_write_en) begin
      wr_count <= wr_count + 1;
      for (int i = 0; i < 4; i++)
        if (ram_write_sel[i]) mem[ram_addr[8:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  logic  prev_we = 1'b0;
  logic  hold_pending = 1'b0;
  wr_t   last_wr;
  wr_t   w;
  resp_t r;

  always @(negedge clk) begin
    if (rst) begin
      if (prev_we && ram_write_en) begin
        checks++;
        $display("FAIL write_en_twice: got 1 expected 0");
      end
      if (hold_pending) begin
        check("whold_en", 32'(ram_en), 32'd1);
        check("whold_we", 32'(ram_write_en), 32'd0);
        check("whold_addr", ram_addr, last_wr.addr);
        check("whold_sel", 32'(ram_write_sel), 32'(last_wr.sel));
        check("whold_wdata", ram_wdata, last_wr.wdata);
      end
      hold_pending <= 1'b0;
      if (ram_write_en) begin
        if (wr_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: got addr %h expected none", ram_addr);
        end else begin
          w = wr_q.pop_front();
          $display("write addr=%h sel=%b wdata=%h", ram_addr, ram_write_sel, ram_wdata);
          check("write_addr", ram_addr, w.addr);
          check("write_sel", 32'(ram_write_sel), 32'(w.sel));
          check("write_wdata", ram_wdata, w.wdata);
          last_wr      <= w;
          hold_pending <= 1'b1;
        end
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_resp: got rdata %h expected none", resp_rdata);
        end else begin
          r = resp_q.pop_front();
          $display("resp cycle=%0d rdata=%h err=%0b", cycle, resp_rdata, resp_err);
          check("resp_rdata", resp_rdata, r.rdata);
          check("resp_err", 32'(resp_err), 32'(r.err));
          check("resp_cycle", 32'(cycle), 32'(r.at));
        end
      end
    end
    prev_we <= ram_write_en;
  end

  // lat = which cycle after the accept edge carries resp_valid.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit keep, input bit push, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat, input bit is_wr,
                       input logic [3:0] exp_sel, input logic [31:0] exp_wdata);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      $display("FAIL accept_timeout: got ready 0 expected 1");
      req_valid = 1'b0;
      return;
    end
    if (push && is_wr) wr_q.push_back('{{addr[31:2], 2'b00}, exp_sel, exp_wdata});
    @(posedge clk);
    #1;
    if (push) resp_q.push_back('{exp_rdata, exp_err, cycle + lat - 1});
    check("ready_low_after_accept", 32'(req_ready), 32'd0);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] exp, input bit keep);
    issue(op, addr, 32'h0, keep, 1'b1, exp, 1'b0, 2, 1'b0, 4'b0000, 32'h0);
  endtask

  task automatic do_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, input logic [31:0] lanes);
    issue(op, addr, wdata, 1'b0, 1'b1, 32'h0, 1'b0, 3, 1'b1, sel, lanes);
  endtask

  task automatic do_bad(input logic [2:0] op, input logic [31:0] addr);
    issue(op, addr, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b1, 1, 1'b0, 4'b0000, 32'h0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (resp_q.size() != 0 || wr_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", resp_q.size() + wr_q.size());
    end
    @(negedge clk);
  endtask

  function automatic logic any_out();
    return resp_valid | resp_err | ram_en | ram_write_en | (|ram_write_sel) |
           (|ram_addr) | (|ram_wdata) | (|resp_rdata);
  endfunction

  initial begin
    int wc;
    int ec;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_outputs_zero", 32'(any_out()), 32'd0);
    rst = 1'b1;

    // Abort a store right after it is accepted.
    wc = wr_count;
    issue(OP_SW, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0, 3, 1'b0, 4'b0000, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midreset_ready", 32'(req_ready), 32'd1);
      check("midreset_outputs_zero", 32'(any_out()), 32'd0);
    end
    check("midreset_no_write", 32'(wr_count), 32'(wc));
    rst = 1'b1;

    do_store(OP_SW, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_store(OP_SB, 32'h13, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    do_load(OP_LW, 32'h10, 32'hA5AD_BEEF, 1'b0);

    do_store(OP_SW, 32'h10, 32'h80FF_7F01, 4'b1111, 32'h80FF_7F01);
    do_load(OP_LB,  32'h13, 32'hFFFF_FF80, 1'b0);
    do_load(OP_LBU, 32'h13, 32'h0000_0080, 1'b0);
    do_load(OP_LH,  32'h12, 32'hFFFF_80FF, 1'b0);
    do_load(OP_LHU, 32'h10, 32'h0000_7F01, 1'b0);
    drain();

    ec = en_count;
    wc = wr_count;
    do_bad(OP_LW, 32'h12);
    do_bad(OP_SH, 32'h201);
    do_bad(OP_SW, 32'h200);
    do_bad(OP_LH, 32'h11);
    drain();
    check("errors_no_ram_en", 32'(en_count), 32'(ec));
    check("errors_no_write", 32'(wr_count), 32'(wc));

    do_store(OP_SH, 32'h12, 32'h0000_1234, 4'b1100, 32'h1234_1234);
    do_load(OP_LHU, 32'h12, 32'h0000_1234, 1'b0);

    // req_valid stays high across three queued loads.
    do_load(OP_LW,  32'h10, 32'h1234_7F01, 1'b1);
    do_load(OP_LBU, 32'h11, 32'h0000_007F, 1'b1);
    do_load(OP_LH,  32'h10, 32'h0000_7F01, 1'b0);
    drain();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
